// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } tPllSeqState;

    // Width of the saturating lock-loss counter.
    localparam int unsigned LOSS_CNT_W  = 8;

    // Retry counter width; MAX_RETRY is limited to 1..15.
    localparam int unsigned RETRY_CNT_W = 4;

    // Bits needed for a counter that runs 0 .. max_count-1 (at least 1 bit).
    function automatic int unsigned timer_width(input int unsigned max_count);
        if (max_count < 2) begin
            return 1;
        end
        return $clog2(max_count);
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to 0.
module bit_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the async input, then re-register to settle metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset-and-lock sequencer: holds the PLL in reset, qualifies lock as
// continuously stable, releases the downstream reset, retries on timeout,
// latches a fault after repeated failures and counts lock losses in RUN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned STABLE_CYC  = 256,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                  piul1RefClock,
    input  logic                  piul1Reset_n,
    input  logic                  piul1Restart,
    input  logic                  piul1PllLocked,
    output logic                  poul1PllReset,
    output logic                  poul1SysReset_n,
    output logic                  poul1Ready,
    output logic                  poul1Fault,
    output logic [LOSS_CNT_W-1:0] poul8LossCount
);

    localparam int unsigned HW = timer_width(HOLD_CYC);
    localparam int unsigned TW = timer_width(TIMEOUT_CYC);
    localparam int unsigned SW = timer_width(STABLE_CYC);

    localparam logic [HW-1:0]          HOLD_LAST   = HW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]          TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0]          STAB_LAST   = SW'(STABLE_CYC - 1);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRY);

    tPllSeqState           state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [SW-1:0]         stab_q, stab_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    logic                  lock_s;
    logic                  restart_q;
    logic                  timeout;
    logic [RETRY_CNT_W-1:0] retry_inc;

    logic                  pll_reset_q;
    logic                  sys_rst_n_q;
    logic                  ready_q;
    logic                  fault_q;
    logic [LOSS_CNT_W-1:0] loss_out_q;

    bit_sync2 u_lock_sync (
        .clk_i  (piul1RefClock),
        .rst_ni (piul1Reset_n),
        .d_i    (piul1PllLocked),
        .q_o    (lock_s)
    );

    // Restart is registered once so it acts on the FSM the cycle after it is sampled.
    always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            restart_q <= 1'b0;
        end else begin
            restart_q <= piul1Restart;
        end
    end

    assign timeout   = (tmo_q == TMO_LAST);
    assign retry_inc = retry_q + RETRY_CNT_W'(1);

    // State, timers, retry and loss counters.
    always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            state_q <= HOLD;
            hold_q  <= '0;
            tmo_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            stab_q  <= stab_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic: restart beats everything, timeout beats lock events.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (restart_q) begin
            state_d = HOLD;
            hold_d  = '0;
            tmo_d   = '0;
            stab_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        hold_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (timeout) begin
                        retry_d = retry_inc;
                        hold_d  = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAULT : HOLD;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                        if (lock_s) begin
                            state_d = STABLE;
                            stab_d  = '0;
                        end
                    end
                end

                STABLE: begin
                    if (timeout) begin
                        retry_d = retry_inc;
                        hold_d  = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAULT : HOLD;
                    end else begin
                        // Timer keeps running across lock drops within one attempt.
                        tmo_d = tmo_q + TW'(1);
                        if (!lock_s) begin
                            state_d = WAIT_LOCK;
                        end else if (stab_q == STAB_LAST) begin
                            state_d = RUN;
                            retry_d = '0;
                        end else begin
                            stab_d = stab_q + SW'(1);
                        end
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + LOSS_CNT_W'(1);
                        end
                    end
                end

                FAULT: begin
                    state_d = FAULT;
                end

                default: begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the state register, one cycle behind it.
    always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            loss_out_q  <= '0;
        end else begin
            pll_reset_q <= (state_q == HOLD) || (state_q == FAULT);
            sys_rst_n_q <= (state_q == RUN);
            ready_q     <= (state_q == RUN);
            fault_q     <= (state_q == FAULT);
            loss_out_q  <= loss_q;
        end
    end

    assign poul1PllReset   = pll_reset_q;
    assign poul1SysReset_n = sys_rst_n_q;
    assign poul1Ready      = ready_q;
    assign poul1Fault      = fault_q;
    assign poul8LossCount  = loss_out_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus pushes each expected output change (cycle and
// values); the monitor pops one entry whenever the DUT outputs change.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       lock;
    logic       pr, sn, rd, ft;
    logic [7:0] loss;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int         cyc;
        logic       pr;
        logic       sn;
        logic       rd;
        logic       ft;
        logic [7:0] loss;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pll_lock_sequencer #(
        .HOLD_CYC    (4),
        .TIMEOUT_CYC (32),
        .STABLE_CYC  (8),
        .MAX_RETRY   (2)
    ) dut (
        .piul1RefClock   (clk),
        .piul1Reset_n    (rst_n),
        .piul1Restart    (restart),
        .piul1PllLocked  (lock),
        .poul1PllReset   (pr),
        .poul1SysReset_n (sn),
        .poul1Ready      (rd),
        .poul1Fault      (ft),
        .poul8LossCount  (loss)
    );

    task automatic push(input string tag, input int c, input logic epr, input logic esn,
                        input logic erd, input logic eft, input logic [7:0] eloss);
        exp_t e;
        e.cyc  = c;
        e.pr   = epr;
        e.sn   = esn;
        e.rd   = erd;
        e.ft   = eft;
        e.loss = eloss;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance to 1 time unit after posedge number c; inputs set here are sampled at edge c+1.
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output change is matched against the next expected entry.
    initial begin : monitor
        logic [11:0] prev;
        logic [11:0] got;
        logic [11:0] want;
        exp_t        e;
        string       tag;
        prev = 'x;
        forever begin
            @(negedge clk);
            got = {pr, sn, rd, ft, loss};
            if (got !== prev) begin
                prev = got;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cyc=%0d pr=%b sn=%b rdy=%b flt=%b loss=%0d, no change expected",
                             cyc, pr, sn, rd, ft, loss);
                end else begin
                    e    = exp_q.pop_front();
                    tag  = tag_q.pop_front();
                    want = {e.pr, e.sn, e.rd, e.ft, e.loss};
                    if (e.cyc != cyc || got !== want) begin
                        errors++;
                        $display("FAIL %s: got cyc=%0d pr=%b sn=%b rdy=%b flt=%b loss=%0d, expected cyc=%0d pr=%b sn=%b rdy=%b flt=%b loss=%0d",
                                 tag, cyc, pr, sn, rd, ft, loss, e.cyc, e.pr, e.sn, e.rd, e.ft, e.loss);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int         t;
        logic [7:0] l;
        exp_t       e;
        string      tag;

        rst_n   = 1'b0;
        restart = 1'b0;
        lock    = 1'b0;
        push("reset_values", 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // 1: clean bring-up; reset released before edge 4, HOLD for 4 cycles.
        go(3);
        rst_n = 1'b1;
        push("s1_pllrst_fall", 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        go(17);
        lock = 1'b1;                                  // arrives at edge 18
        push("s1_sysrst_rise", 29, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        // 6A: lock drop and restart reach the FSM together (sync delay 2, restart delay 1).
        go(33);
        lock = 1'b0;                                  // arrives 34
        push("s6a_restart_wins", 37, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        go(34);
        restart = 1'b1;                               // arrives 35
        go(35);
        restart = 1'b0;
        push("s6a_pllrst_fall", 41, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // 2: lock glitch; high 44..48, low 49, high from 50.
        go(43);
        lock = 1'b1;
        push("s2_run_after_glitch", 61, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        go(48);
        lock = 1'b0;
        go(49);
        lock = 1'b1;

        // 3: lock lost in RUN, then never returns: two timeouts, then FAULT.
        go(65);
        lock = 1'b0;                                  // arrives 66
        push("s3_loss_to_hold", 69, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        push("s3_try1_pllrst_fall", 73, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        push("s3_try1_timeout", 105, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        push("s3_try2_pllrst_fall", 109, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        push("s3_fault", 141, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);

        // 4: lock present in FAULT, then restart pulse.
        go(150);
        lock = 1'b1;
        go(159);
        restart = 1'b1;                               // arrives 160
        push("s4_fault_clear", 162, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        push("s4_pllrst_fall", 166, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        push("s4_run", 175, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        go(160);
        restart = 1'b0;

        // 5: 257 one-cycle lock drops in RUN; count saturates at 255.
        l = 8'd1;
        for (int i = 0; i < 257; i++) begin
            t = 180 + 20 * i;
            go(t - 1);
            lock = 1'b0;                              // arrives t
            l = (l == 8'd255) ? 8'd255 : l + 8'd1;
            push("s5_loss", t + 3, 1'b1, 1'b0, 1'b0, 1'b0, l);
            push("s5_pllrst_fall", t + 7, 1'b0, 1'b0, 1'b0, 1'b0, l);
            push("s5_relock_run", t + 16, 1'b0, 1'b1, 1'b1, 1'b0, l);
            go(t);
            lock = 1'b1;                              // arrives t+1
        end

        // 6B: restart into a new attempt, then async reset while in STABLE.
        go(5319);
        restart = 1'b1;                               // arrives 5320
        push("s6b_restart", 5322, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
        push("s6b_pllrst_fall", 5326, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
        go(5320);
        restart = 1'b0;
        go(5329);
        push("s6b_async_reset", 5329, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b0;
        go(5335);
        rst_n = 1'b1;
        push("s6b_pllrst_fall_after_reset", 5340, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        push("s6b_run_after_reset", 5349, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        go(5360);
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no output change, expected cyc=%0d pr=%b sn=%b rdy=%b flt=%b loss=%0d",
                     tag, e.cyc, e.pr, e.sn, e.rd, e.ft, e.loss);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
